// File: rtl/imem_fetch_ctrl.sv
// rtl/imem_fetch_ctrl.sv - instruction fetch sequencer and loader/fetch arbiter for the instruction memory
// Owns the PC, issues one read per cycle in RUN, and registers the word into a one-entry valid/ready stage.
module imem_fetch_ctrl #(
   parameter int AW = 10,
   parameter int DW = 32,
   parameter logic [DW-1:0] HALT_WORD = 32'h00000000
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          ld_valid,
   input  logic [AW-1:0] ld_addr,
   input  logic [DW-1:0] ld_data,
   output logic          ld_ack,
   output logic [AW-1:0] imem_addr,
   output logic          imem_we,
   output logic [DW-1:0] imem_wdata,
   input  logic [DW-1:0] imem_rdata,
   input  logic          br_taken,
   input  logic [AW-1:0] br_target,
   output logic          inst_valid,
   input  logic          inst_ready,
   output logic [DW-1:0] inst,
   output logic [AW-1:0] inst_pc,
   output logic          running,
   output logic [15:0]   fetch_cnt
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] pc_q, pc_d;
   logic [AW-1:0] inst_pc_q, inst_pc_d;
   logic [DW-1:0] inst_q, inst_d;
   logic          inst_valid_q, inst_valid_d;
   logic          ld_ack_q, ld_ack_d;
   logic [15:0]   fetch_cnt_q, fetch_cnt_d;
   logic          slot_free;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         pc_q         <= '0;
         inst_pc_q    <= '0;
         inst_q       <= '0;
         inst_valid_q <= 1'b0;
         ld_ack_q     <= 1'b0;
         fetch_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         inst_pc_q    <= inst_pc_d;
         inst_q       <= inst_d;
         inst_valid_q <= inst_valid_d;
         ld_ack_q     <= ld_ack_d;
         fetch_cnt_q  <= fetch_cnt_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      inst_pc_d    = inst_pc_q;
      inst_d       = inst_q;
      inst_valid_d = inst_valid_q;
      ld_ack_d     = 1'b0;
      fetch_cnt_d  = fetch_cnt_q;
      imem_addr    = ld_addr;
      imem_we      = 1'b0;
      slot_free    = !inst_valid_q || inst_ready;

      case (state_q)
         S_RUN: begin
            imem_addr = pc_q;
            // A redirect flushes the output stage and outranks both load and halt detection.
            if (br_taken) begin
               pc_d         = br_target;
               inst_valid_d = 1'b0;
            end else if (slot_free) begin
               if (imem_rdata == HALT_WORD) begin
                  state_d = S_HALT;
                  if (inst_ready) begin
                     inst_valid_d = 1'b0;
                  end
               end else begin
                  inst_d       = imem_rdata;
                  inst_pc_d    = pc_q;
                  inst_valid_d = 1'b1;
                  pc_d         = pc_q + AW'(1);
                  if (fetch_cnt_q != 16'hFFFF) begin
                     fetch_cnt_d = fetch_cnt_q + 16'd1;
                  end
               end
            end
         end
         default: begin
            // Loader owns the memory; a held instruction may still drain to decode.
            imem_we  = ld_valid;
            ld_ack_d = ld_valid;
            if (inst_ready) begin
               inst_valid_d = 1'b0;
            end
            if (start) begin
               state_d     = S_RUN;
               pc_d        = '0;
               fetch_cnt_d = '0;
            end
         end
      endcase
   end

   assign imem_wdata = ld_data;
   assign ld_ack     = ld_ack_q;
   assign inst_valid = inst_valid_q;
   assign inst       = inst_q;
   assign inst_pc    = inst_pc_q;
   assign running    = (state_q == S_RUN);
   assign fetch_cnt  = fetch_cnt_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb/tb_imem_fetch_ctrl.sv - self-checking bench for imem_fetch_ctrl
module tb_imem_fetch_ctrl;

   localparam logic [31:0] I_ADD = 32'h002080B3;
   localparam logic [31:0] I_SUB = 32'h40310133;
   localparam logic [31:0] I_OR  = 32'h0041E1B3;
   localparam logic [31:0] I_AND = 32'h00527233;

   logic        clk;
   logic        reset;
   logic        start;
   logic        ld_valid;
   logic [9:0]  ld_addr;
   logic [31:0] ld_data;
   logic        ld_ack;
   logic [9:0]  imem_addr;
   logic        imem_we;
   logic [31:0] imem_wdata;
   logic [31:0] imem_rdata;
   logic        br_taken;
   logic [9:0]  br_target;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [9:0]  inst_pc;
   logic        running;
   logic [15:0] fetch_cnt;

   imem_fetch_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .ld_valid   (ld_valid),
      .ld_addr    (ld_addr),
      .ld_data    (ld_data),
      .ld_ack     (ld_ack),
      .imem_addr  (imem_addr),
      .imem_we    (imem_we),
      .imem_wdata (imem_wdata),
      .imem_rdata (imem_rdata),
      .br_taken   (br_taken),
      .br_target  (br_target),
      .inst_valid (inst_valid),
      .inst_ready (inst_ready),
      .inst       (inst),
      .inst_pc    (inst_pc),
      .running    (running),
      .fetch_cnt  (fetch_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Environment memory: combinational read, synchronous write.
   logic [31:0] mem [0:1023] = '{default: 32'h0};
   assign imem_rdata = mem[imem_addr];
   always @(posedge clk) if (imem_we) mem[imem_addr] <= imem_wdata;

   // Reference model: run flag, PC as an integer, output stage as a queue of at most one entry.
   typedef struct {
      logic [31:0] w;
      int          pc;
   } slot_t;
   logic [31:0] ref_mem [0:1023] = '{default: 32'h0};
   bit    m_run;
   int    m_pc;
   int    m_cnt;
   bit    m_ack;
   slot_t m_slot[$];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_run = 1'b0;
      m_pc  = 0;
      m_cnt = 0;
      m_ack = 1'b0;
      m_slot.delete();
   endtask

   task automatic model_step();
      if (!m_run) begin
         if (ld_valid) ref_mem[ld_addr] = ld_data;
         m_ack = ld_valid;
         if (m_slot.size() != 0 && inst_ready) m_slot.delete();
         if (start) begin
            m_run = 1'b1;
            m_pc  = 0;
            m_cnt = 0;
         end
      end else begin
         m_ack = 1'b0;
         if (br_taken) begin
            m_slot.delete();
            m_pc = int'(br_target);
         end else if (m_slot.size() == 0 || inst_ready) begin
            if (ref_mem[m_pc] == 32'h0) begin
               if (inst_ready) m_slot.delete();
               m_run = 1'b0;
            end else begin
               m_slot.delete();
               m_slot.push_back('{ref_mem[m_pc], m_pc});
               m_pc = (m_pc + 1) % 1024;
               if (m_cnt < 65535) m_cnt++;
            end
         end
      end
   endtask

   task automatic check_comb();
      int exp_addr;
      exp_addr = m_run ? m_pc : int'(ld_addr);
      check("imem_addr", 64'(imem_addr), 64'(exp_addr));
      check("imem_we", 64'(imem_we), 64'(!m_run && ld_valid));
      check("imem_wdata", 64'(imem_wdata), 64'(ld_data));
   endtask

   task automatic check_regs();
      check("running", 64'(running), 64'(m_run));
      check("ld_ack", 64'(ld_ack), 64'(m_ack));
      check("fetch_cnt", 64'(fetch_cnt), 64'(m_cnt));
      check("inst_valid", 64'(inst_valid), 64'(m_slot.size() != 0));
      if (m_slot.size() != 0) begin
         check("inst", 64'(inst), 64'(m_slot[0].w));
         check("inst_pc", 64'(inst_pc), 64'(m_slot[0].pc));
      end
   endtask

   task automatic cycle();
      #1;
      check_comb();
      model_step();
      @(posedge clk);
      #1;
      check_regs();
   endtask

   task automatic idle_inputs();
      start      = 1'b0;
      ld_valid   = 1'b0;
      ld_addr    = '0;
      ld_data    = '0;
      br_taken   = 1'b0;
      br_target  = '0;
      inst_ready = 1'b0;
   endtask

   task automatic load_word(input logic [9:0] a, input logic [31:0] d);
      idle_inputs();
      ld_valid = 1'b1;
      ld_addr  = a;
      ld_data  = d;
      cycle();
   endtask

   task automatic do_start(input bit rdy);
      idle_inputs();
      start      = 1'b1;
      inst_ready = rdy;
      cycle();
   endtask

   task automatic run_to_halt(input string nm);
      idle_inputs();
      inst_ready = 1'b1;
      for (int i = 0; i < 40 && running; i++) cycle();
      check(nm, 64'(running), 64'(0));
   endtask

   function automatic logic [9:0] pick_addr();
      int r;
      r = $urandom_range(0, 19);
      return (r < 16) ? 10'(r) : 10'(1004 + r);
   endfunction

   typedef struct {
      bit          start;
      bit          ldv;
      logic [9:0]  la;
      logic [31:0] ld;
      bit          rdy;
      bit          e_valid;
      logic [9:0]  e_pc;
      logic [31:0] e_inst;
      bit          e_run;
      bit          e_ack;
      logic [15:0] e_cnt;
   } vec_t;

   vec_t tbl[12];
   int   seen[$];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      idle_inputs();
      reset = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      check("rst_valid", 64'(inst_valid), 64'(0));
      check("rst_inst", 64'(inst), 64'(0));
      check("rst_inst_pc", 64'(inst_pc), 64'(0));
      check("rst_ack", 64'(ld_ack), 64'(0));
      check("rst_cnt", 64'(fetch_cnt), 64'(0));
      check("rst_running", 64'(running), 64'(0));
      reset = 1'b0;

      // Program load, start, straight-line run and halt at word 4.
      tbl[0]  = '{0, 1, 10'd0, I_ADD, 0,  0, 10'd0, 32'h0, 0, 1, 16'd0};
      tbl[1]  = '{0, 1, 10'd1, I_SUB, 0,  0, 10'd0, 32'h0, 0, 1, 16'd0};
      tbl[2]  = '{0, 1, 10'd2, I_OR,  0,  0, 10'd0, 32'h0, 0, 1, 16'd0};
      tbl[3]  = '{0, 1, 10'd3, I_AND, 0,  0, 10'd0, 32'h0, 0, 1, 16'd0};
      tbl[4]  = '{0, 1, 10'd4, 32'h0, 0,  0, 10'd0, 32'h0, 0, 1, 16'd0};
      tbl[5]  = '{1, 0, 10'd0, 32'h0, 0,  0, 10'd0, 32'h0, 1, 0, 16'd0};
      tbl[6]  = '{0, 0, 10'd0, 32'h0, 1,  1, 10'd0, I_ADD, 1, 0, 16'd1};
      tbl[7]  = '{0, 0, 10'd0, 32'h0, 1,  1, 10'd1, I_SUB, 1, 0, 16'd2};
      tbl[8]  = '{0, 0, 10'd0, 32'h0, 1,  1, 10'd2, I_OR,  1, 0, 16'd3};
      tbl[9]  = '{0, 0, 10'd0, 32'h0, 1,  1, 10'd3, I_AND, 1, 0, 16'd4};
      tbl[10] = '{0, 0, 10'd0, 32'h0, 1,  0, 10'd0, 32'h0, 0, 0, 16'd4};
      tbl[11] = '{0, 0, 10'd0, 32'h0, 1,  0, 10'd0, 32'h0, 0, 0, 16'd4};
      for (int i = 0; i < 12; i++) begin
         idle_inputs();
         start      = tbl[i].start;
         ld_valid   = tbl[i].ldv;
         ld_addr    = tbl[i].la;
         ld_data    = tbl[i].ld;
         inst_ready = tbl[i].rdy;
         cycle();
         check($sformatf("tbl%0d_valid", i), 64'(inst_valid), 64'(tbl[i].e_valid));
         if (tbl[i].e_valid) begin
            check($sformatf("tbl%0d_pc", i), 64'(inst_pc), 64'(tbl[i].e_pc));
            check($sformatf("tbl%0d_inst", i), 64'(inst), 64'(tbl[i].e_inst));
         end
         check($sformatf("tbl%0d_run", i), 64'(running), 64'(tbl[i].e_run));
         check($sformatf("tbl%0d_ack", i), 64'(ld_ack), 64'(tbl[i].e_ack));
         check($sformatf("tbl%0d_cnt", i), 64'(fetch_cnt), 64'(tbl[i].e_cnt));
      end

      // Backpressure: first word held for three cycles, then the rest follows without loss or repeat.
      do_start(1'b0);
      idle_inputs();
      cycle();
      for (int i = 0; i < 3; i++) begin
         cycle();
         check("bp_inst", 64'(inst), 64'(I_ADD));
         check("bp_inst_pc", 64'(inst_pc), 64'(0));
         check("bp_addr", 64'(imem_addr), 64'(1));
      end
      seen.delete();
      seen.push_back(int'(inst_pc));
      inst_ready = 1'b1;
      for (int i = 0; i < 10 && running; i++) begin
         cycle();
         if (inst_valid) seen.push_back(int'(inst_pc));
      end
      check("bp_halted", 64'(running), 64'(0));
      check("bp_count", 64'(seen.size()), 64'(4));
      for (int i = 0; i < seen.size() && i < 4; i++) check("bp_order", 64'(seen[i]), 64'(i));

      // Branch while inst_pc=3 is presented.
      do_start(1'b1);
      idle_inputs();
      inst_ready = 1'b1;
      for (int i = 0; i < 10 && !(inst_valid && inst_pc == 10'd3); i++) cycle();
      check("br_reach3", 64'(inst_pc), 64'(3));
      br_taken  = 1'b1;
      br_target = 10'd1;
      cycle();
      check("br_flush", 64'(inst_valid), 64'(0));
      br_taken = 1'b0;
      cycle();
      check("br_tgt_valid", 64'(inst_valid), 64'(1));
      check("br_tgt_pc", 64'(inst_pc), 64'(1));
      check("br_tgt_inst", 64'(inst), 64'(I_SUB));
      run_to_halt("br_halt");
      check("br_cnt", 64'(fetch_cnt), 64'(7));

      // Wrap: 1023 -> 0 with a halt word at 0.
      load_word(10'd1023, I_ADD);
      load_word(10'd0, 32'h0);
      do_start(1'b1);
      idle_inputs();
      inst_ready = 1'b1;
      br_taken   = 1'b1;
      br_target  = 10'd1023;
      cycle();
      check("wrap_br_run", 64'(running), 64'(1));
      br_taken = 1'b0;
      cycle();
      check("wrap_pc1023", 64'(inst_pc), 64'(1023));
      check("wrap_valid", 64'(inst_valid), 64'(1));
      cycle();
      check("wrap_halt", 64'(running), 64'(0));
      check("wrap_cnt", 64'(fetch_cnt), 64'(1));

      // Loader ignored during RUN; write plus start accepted together in HALT.
      load_word(10'd0, I_ADD);
      do_start(1'b0);
      idle_inputs();
      cycle();
      for (int i = 0; i < 2; i++) begin
         ld_valid = 1'b1;
         ld_addr  = 10'd500;
         ld_data  = 32'hDEADBEEF;
         #1;
         check("run_ld_we", 64'(imem_we), 64'(0));
         cycle();
         check("run_ld_ack", 64'(ld_ack), 64'(0));
      end
      check("run_ld_mem", 64'(mem[500]), 64'(0));
      run_to_halt("ld_halt");
      idle_inputs();
      ld_valid = 1'b1;
      ld_addr  = 10'd5;
      ld_data  = 32'hCAFE0001;
      start    = 1'b1;
      cycle();
      check("ldst_ack", 64'(ld_ack), 64'(1));
      check("ldst_run", 64'(running), 64'(1));
      check("ldst_mem", 64'(mem[5]), 64'(32'hCAFE0001));
      idle_inputs();
      inst_ready = 1'b1;
      cycle();
      check("ldst_pc0", 64'(inst_pc), 64'(0));
      run_to_halt("ldst_halt");

      // Asynchronous reset mid-RUN with a valid instruction held.
      do_start(1'b0);
      idle_inputs();
      cycle();
      check("ar_pre_valid", 64'(inst_valid), 64'(1));
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      #1;
      check("ar_valid", 64'(inst_valid), 64'(0));
      check("ar_running", 64'(running), 64'(0));
      check("ar_cnt", 64'(fetch_cnt), 64'(0));
      check("ar_inst_pc", 64'(inst_pc), 64'(0));
      @(posedge clk);
      #1;
      reset = 1'b0;
      do_start(1'b0);
      idle_inputs();
      inst_ready = 1'b1;
      cycle();
      check("ar_refetch_pc", 64'(inst_pc), 64'(0));
      check("ar_refetch_inst", 64'(inst), 64'(I_ADD));
      run_to_halt("ar_halt");

      // Randomized traffic against the reference model.
      for (int n = 0; n < 3000; n++) begin
         start      = ($urandom_range(0, 15) == 0);
         ld_valid   = ($urandom_range(0, 3) == 0);
         ld_addr    = pick_addr();
         ld_data    = ($urandom_range(0, 7) == 0) ? 32'h0 : 32'($urandom);
         inst_ready = ($urandom_range(0, 9) < 7);
         br_taken   = ($urandom_range(0, 9) == 0);
         br_target  = pick_addr();
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
